// File: rtl/vedic_mac8.sv
// Streaming unsigned 8x8 multiply-accumulate: operand register, Vedic multiplier,
// product register, accumulator and a single-entry valid/ready result register.

module vedic2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_c1;
  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
  assign w_c1   = (i_a[1] & i_b[0]) & (i_a[0] & i_b[1]);
  assign o_p[2] = (i_a[1] & i_b[1]) ^ w_c1;
  assign o_p[3] = (i_a[1] & i_b[1]) & w_c1;
endmodule

module vedic4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  vedic2x2 u_m0 (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_q0));
  vedic2x2 u_m1 (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_q1));
  vedic2x2 u_m2 (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_q2));
  vedic2x2 u_m3 (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_q3));
  // Urdhva-tiryak: cross products land at the middle weight
  assign o_p = {4'b0, w_q0} + {2'b0, w_q1, 2'b0} + {2'b0, w_q2, 2'b0} + {w_q3, 4'b0};
endmodule

module vedic8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_q0, w_q1, w_q2, w_q3;
  vedic4x4 u_m0 (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_q0));
  vedic4x4 u_m1 (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_q1));
  vedic4x4 u_m2 (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_q2));
  vedic4x4 u_m3 (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_q3));
  assign o_p = {8'b0, w_q0} + {4'b0, w_q1, 4'b0} + {4'b0, w_q2, 4'b0} + {w_q3, 8'b0};
endmodule

module vedic_mac8 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_v1, r_last1, r_v2, r_last2, r_ovf;
  logic [7:0]       r_a, r_b;
  logic [15:0]      r_prod;
  logic [ACC_W-1:0] r_acc, r_out_sum;
  logic [CNT_W-1:0] r_cnt, r_out_cnt;
  logic             r_out_valid, r_out_ovf;

  logic             w_en, w_acc_step, w_load;
  logic [15:0]      w_p;
  logic [ACC_W:0]   w_nxt;

  // A held, unconsumed result freezes the whole pipeline
  assign w_en       = !(r_out_valid && !out_ready);
  assign in_ready   = w_en && !acc_clr;
  assign w_acc_step = !acc_clr && w_en && r_v2;
  assign w_load     = w_acc_step && r_last2;
  assign w_nxt      = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, r_prod};

  vedic8x8 u_mul (.i_a(r_a), .i_b(r_b), .o_p(w_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0; r_last1 <= 1'b0; r_a <= '0; r_b <= '0;
      r_v2 <= 1'b0; r_last2 <= 1'b0; r_prod <= '0;
    end else if (acc_clr) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid; r_last1 <= in_last; r_a <= in_a; r_b <= in_b;
      r_v2 <= r_v1; r_last2 <= r_last1; r_prod <= w_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0; r_cnt <= '0; r_ovf <= 1'b0;
    end else if (acc_clr || w_load) begin
      r_acc <= '0; r_cnt <= '0; r_ovf <= 1'b0;
    end else if (w_acc_step) begin
      r_acc <= w_nxt[ACC_W-1:0];
      r_cnt <= r_cnt + CNT_ONE;
      r_ovf <= r_ovf | w_nxt[ACC_W];
    end
  end

  // A new result may replace one being consumed in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0; r_out_sum <= '0; r_out_cnt <= '0; r_out_ovf <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_nxt[ACC_W-1:0];
      r_out_cnt   <= r_cnt + CNT_ONE;
      r_out_ovf   <= r_ovf | w_nxt[ACC_W];
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_vedic_mac8.sv
// Directed self-checking bench for vedic_mac8 (ACC_W=16 so wrap is reachable).

module tb_vedic_mac8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last, acc_clr;
  logic [7:0]       in_a, in_b;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] dlv_sum[$];
  logic [31:0] dlv_cnt[$];

  vedic_mac8 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) begin
      dlv_sum.push_back(32'(out_sum));
      dlv_cnt.push_back(32'(out_cnt));
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
    in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum",   32'(out_sum),   0);
    chk("rst_cnt",   32'(out_cnt),   0);
    chk("rst_ovf",   32'(out_ovf),   0);
    #10 rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(in_ready),  1);
    chk("idle_valid", 32'(out_valid), 0);

    // streamed vector, checking latency
    send(8'd3, 8'd4, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    send(8'd10, 8'd20, 1'b1);
    chk("lat_n0", 32'(out_valid), 0);
    step();
    chk("lat_n1", 32'(out_valid), 0);
    step();
    chk("lat_n2", 32'(out_valid), 1);
    chk("v1_sum", 32'(out_sum), 65237);
    chk("v1_cnt", 32'(out_cnt), 3);
    chk("v1_ovf", 32'(out_ovf), 0);
    pop();
    chk("v1_popped", 32'(out_valid), 0);

    // overflow at 16 bits
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    wait_out("ov2_wait", 8);
    chk("ov2_sum", 32'(out_sum), 32'hFC02);
    chk("ov2_cnt", 32'(out_cnt), 2);
    chk("ov2_ovf", 32'(out_ovf), 1);
    pop();
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    wait_out("ov3_wait", 8);
    chk("ov3_sum", 32'(out_sum), 32'hFA03);
    chk("ov3_cnt", 32'(out_cnt), 3);
    chk("ov3_ovf", 32'(out_ovf), 1);
    pop();

    // back-to-back vectors under backpressure
    dlv_sum.delete(); dlv_cnt.delete();
    send(8'd2, 8'd3, 1'b1);
    send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_sum",   32'(out_sum),   6);
      chk("bp_ready", 32'(in_ready),  0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    chk("bp_ndlv", 32'(dlv_sum.size()), 2);
    if (dlv_sum.size() == 2) begin
      chk("bp_d0_sum", dlv_sum[0], 6);
      chk("bp_d0_cnt", dlv_cnt[0], 1);
      chk("bp_d1_sum", dlv_sum[1], 5);
      chk("bp_d1_cnt", dlv_cnt[1], 2);
    end
    chk("bp_drained", 32'(out_valid), 0);

    // flush with two terms in flight and a result held
    send(8'd4, 8'd5, 1'b1);
    send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd2, 1'b0);
    chk("clr_held", 32'(out_sum), 20);
    acc_clr = 1'b1;
    #1;
    chk("clr_ready", 32'(in_ready), 0);
    step();
    acc_clr = 1'b0;
    chk("clr_keep_valid", 32'(out_valid), 1);
    chk("clr_keep_sum",   32'(out_sum),   20);
    pop();
    chk("clr_popped", 32'(out_valid), 0);
    send(8'd7, 8'd8, 1'b1);
    wait_out("clr_wait", 8);
    chk("clr_sum", 32'(out_sum), 56);
    chk("clr_cnt", 32'(out_cnt), 1);
    chk("clr_ovf", 32'(out_ovf), 0);
    pop();

    // asynchronous reset mid-vector with a held result
    send(8'd3, 8'd3, 1'b1);
    send(8'd5, 8'd5, 1'b0);
    step();
    chk("mr_held", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_drop", 32'(out_valid), 0);
    #2 rst_n = 1'b1;
    step();
    send(8'd9, 8'd9, 1'b1);
    wait_out("mr_wait", 8);
    chk("mr_sum", 32'(out_sum), 81);
    chk("mr_cnt", 32'(out_cnt), 1);
    chk("mr_ovf", 32'(out_ovf), 0);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
